// File: rtl/reg_scan_pkg.sv
// reg_scan_pkg
// Shared types and constants for the register-file scanner.
//   state_t   : scanner FSM encoding (IDLE, DUMP, LOAD, DONE)
//   MODE_DUMP : mode value selecting a register-file read-out
//   MODE_LOAD : mode value selecting a register-file preload
package reg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    LOAD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

endpackage

// File: rtl/reg_file.sv
// reg_file
// Simple register file with two combinational read ports and one write port.
// Storage is deliberately not reset, so contents survive a scanner reset.
// Addresses at or beyond LENGTH read as zero and ignore writes.
//   clk                 : rising-edge clock
//   rd_addr1 / rd_data1 : read port 1 (combinational)
//   rd_addr2 / rd_data2 : read port 2 (combinational)
//   wr_en, wr_addr, wr_data : write port, lands on the next rising edge
module reg_file #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 4,
  localparam int ADDR_WIDTH = $clog2(LENGTH)
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  output logic [WIDTH-1:0]      rd_data1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic [WIDTH-1:0]      rd_data2,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data
);

  // One extra bit so that LENGTH itself is representable in the compare.
  localparam logic [ADDR_WIDTH:0] LEN_EXT = (ADDR_WIDTH+1)'(LENGTH);

  logic [WIDTH-1:0] mem_q [LENGTH];

  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < LEN_EXT)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if ({1'b0, rd_addr1} < LEN_EXT) rd_data1 = mem_q[rd_addr1];
    if ({1'b0, rd_addr2} < LEN_EXT) rd_data2 = mem_q[rd_addr2];
  end

endmodule

// File: rtl/reg_scan.sv
// reg_scan
// Walks every register-file address in order on command.
//   Dump mode: reads each register and streams it out (out_data/out_valid/
//              out_last, registered) under out_ready backpressure.
//   Load mode: accepts in_data/in_valid words (in_ready high while loading)
//              and writes them to consecutive registers.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, mode         : command strobe and mode, sampled only in IDLE
//   busy, done          : busy through DUMP/LOAD/DONE; done pulses in DONE
//   rf_rd_addr/rf_rd_data             : register file read port
//   rf_wr_addr/rf_wr_data/rf_wr_en    : register file write port
//   out_data/out_valid/out_last/out_ready : dump stream
//   in_data/in_valid/in_ready             : load stream
//   dbg_state           : current FSM state for observation
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. The producer holds valid and data stable until that transfer; the
// consumer may raise or drop ready at any time.
module reg_scan
  import reg_scan_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 4,
  localparam int ADDR_WIDTH = $clog2(LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr,
  input  logic [WIDTH-1:0]      rf_rd_data,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [WIDTH-1:0]      rf_wr_data,
  output logic                  rf_wr_en,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output state_t                dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LENGTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  issued_q, issued_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  beat_load;

  // State register (all flops).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      issued_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      issued_q    <= issued_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (mode == MODE_LOAD) ? LOAD : DUMP;
      DUMP: if (out_valid_q && out_ready && out_last_q) state_d = DONE;
      LOAD: if (in_valid && (idx_q == LAST_IDX)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: address walk and the single registered output beat.
  always_comb begin
    idx_d       = idx_q;
    issued_d    = issued_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    // The beat register can take a new word when it is empty or draining now.
    beat_load   = (state_q == DUMP) && !issued_q && (!out_valid_q || out_ready);
    case (state_q)
      DUMP: begin
        if (beat_load) begin
          out_data_d  = rf_rd_data;
          out_valid_d = 1'b1;
          out_last_d  = (idx_q == LAST_IDX);
          // Hold idx at the last address instead of wrapping; issued marks
          // that every address has been read.
          if (idx_q == LAST_IDX) issued_d = 1'b1;
          else                   idx_d    = idx_q + 1'b1;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      LOAD: begin
        // On the final handshake idx stays put; DONE clears it.
        if (in_valid && (idx_q != LAST_IDX)) idx_d = idx_q + 1'b1;
      end
      DONE: begin
        idx_d    = '0;
        issued_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    in_ready   = (state_q == LOAD);
    rf_wr_en   = (state_q == LOAD) && in_valid;
    rf_wr_addr = idx_q;
    rf_wr_data = in_data;
    rf_rd_addr = idx_q;
    out_data   = out_data_q;
    out_valid  = out_valid_q;
    out_last   = out_last_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_reg_scan.sv
module tb_reg_scan;
  import reg_scan_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // ---------------- DUT A: WIDTH 8, LENGTH 4 ----------------
  logic       a_start = 0, a_mode = 0, a_busy, a_done;
  logic [1:0] a_rd_addr, a_wr_addr, a_rd_addr2 = '0;
  logic [7:0] a_rd_data, a_wr_data, a_rd_data2, a_out_data, a_in_data = '0;
  logic       a_wr_en, a_out_valid, a_out_last, a_out_ready = 0;
  logic       a_in_valid = 0, a_in_ready;
  state_t     a_state;

  reg_scan #(.WIDTH(8), .LENGTH(4)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .mode(a_mode),
    .busy(a_busy), .done(a_done),
    .rf_rd_addr(a_rd_addr), .rf_rd_data(a_rd_data),
    .rf_wr_addr(a_wr_addr), .rf_wr_data(a_wr_data), .rf_wr_en(a_wr_en),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_last(a_out_last),
    .out_ready(a_out_ready),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .dbg_state(a_state)
  );

  reg_file #(.WIDTH(8), .LENGTH(4)) u_a_rf (
    .clk(clk),
    .rd_addr1(a_rd_addr), .rd_data1(a_rd_data),
    .rd_addr2(a_rd_addr2), .rd_data2(a_rd_data2),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data)
  );

  // ---------------- DUT B: WIDTH 16, LENGTH 3 ----------------
  logic        b_start = 0, b_mode = 0, b_busy, b_done;
  logic [1:0]  b_rd_addr, b_wr_addr, b_rd_addr2 = '0;
  logic [15:0] b_rd_data, b_wr_data, b_rd_data2, b_out_data, b_in_data = '0;
  logic        b_wr_en, b_out_valid, b_out_last, b_out_ready = 0;
  logic        b_in_valid = 0, b_in_ready;
  state_t      b_state;

  reg_scan #(.WIDTH(16), .LENGTH(3)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .mode(b_mode),
    .busy(b_busy), .done(b_done),
    .rf_rd_addr(b_rd_addr), .rf_rd_data(b_rd_data),
    .rf_wr_addr(b_wr_addr), .rf_wr_data(b_wr_data), .rf_wr_en(b_wr_en),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_last(b_out_last),
    .out_ready(b_out_ready),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .dbg_state(b_state)
  );

  reg_file #(.WIDTH(16), .LENGTH(3)) u_b_rf (
    .clk(clk),
    .rd_addr1(b_rd_addr), .rd_data1(b_rd_data),
    .rd_addr2(b_rd_addr2), .rd_data2(b_rd_data2),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
  );

  // ---------------- monitors ----------------
  int   a_done_cnt = 0;
  int   b_done_cnt = 0;
  logic b_bad_addr = 1'b0;
  always @(posedge clk) begin
    if (a_done) a_done_cnt = a_done_cnt + 1;
    if (b_done) b_done_cnt = b_done_cnt + 1;
    if (b_rd_addr > 2'd2 || (b_wr_en && b_wr_addr > 2'd2)) b_bad_addr = 1'b1;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reg_a(input logic [1:0] addr, input logic [7:0] exp);
    a_rd_addr2 = addr;
    #1;
    chk($sformatf("a_reg%0d", addr), 32'(a_rd_data2), 32'(exp));
  endtask

  // Load driver: vpat[i] is in_valid for cycle i of LOAD; words packed LSB first.
  task automatic load_a(input logic [31:0] words, input logic [15:0] vpat, input int vlen);
    int n, c0;
    n  = 0;
    c0 = a_done_cnt;
    a_mode  = MODE_LOAD;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < vlen; i++) begin
      a_in_valid = vpat[i];
      a_in_data  = vpat[i] ? words[n*8 +: 8] : 8'hEE;
      #1;
      chk("load_in_ready", 32'(a_in_ready), 32'd1);
      chk("load_busy", 32'(a_busy), 32'd1);
      chk("load_wr_en", 32'(a_wr_en), 32'(vpat[i]));
      if (vpat[i]) begin
        chk("load_wr_addr", 32'(a_wr_addr), 32'(n));
        chk("load_wr_data", 32'(a_wr_data), 32'(words[n*8 +: 8]));
        n++;
      end
      tick();
    end
    a_in_valid = 1'b0;
    #1;
    chk("load_done_pulse", 32'(a_done), 32'd1);
    chk("load_done_busy", 32'(a_busy), 32'd1);
    chk("load_done_in_ready", 32'(a_in_ready), 32'd0);
    chk_reg_a(2'd3, words[31:24]);
    tick();
    chk("load_idle_busy", 32'(a_busy), 32'd0);
    chk("load_done_count", 32'(a_done_cnt - c0), 32'd1);
  endtask

  // Dump driver: rpat[k] is out_ready in cycle k+2 after the start edge,
  // 1 elsewhere. Beats are checked against exp_q.
  task automatic dump_a(input logic [15:0] rpat, input int rlen,
                        input int exp_first, input int exp_done, input bit poke);
    int cyc, first, done_c, c0;
    logic [7:0] pd, exp;
    logic pv, pl, stalled;
    first = -1; done_c = -1; stalled = 1'b0; c0 = a_done_cnt;
    pd = '0; pv = 1'b0; pl = 1'b0;
    a_mode  = MODE_DUMP;
    a_start = 1'b1;
    tick();
    cyc = 1;
    while (cyc < 40) begin
      a_out_ready = (cyc >= 2 && cyc - 2 < rlen) ? rpat[cyc-2] : 1'b1;
      a_start     = poke && (cyc == 3);
      #1;
      if (stalled) begin
        chk("stall_data", 32'(a_out_data), 32'(pd));
        chk("stall_valid", 32'(a_out_valid), 32'(pv));
        chk("stall_last", 32'(a_out_last), 32'(pl));
      end
      if (a_out_valid && first < 0) first = cyc;
      if (a_done) begin
        done_c = cyc;
        chk("dump_done_valid", 32'(a_out_valid), 32'd0);
        a_start = poke;
        tick();
        a_start = 1'b0;
        break;
      end
      if (a_out_valid && a_out_ready) begin
        if (exp_q.size() == 0) begin
          chk("dump_extra_beat", 32'(a_out_data), 32'hFFFF_FFFF);
        end else begin
          exp = exp_q.pop_front();
          chk("dump_data", 32'(a_out_data), 32'(exp));
          chk("dump_last", 32'(a_out_last), 32'(exp_q.size() == 0));
        end
      end
      stalled = a_out_valid && !a_out_ready;
      pd = a_out_data; pv = a_out_valid; pl = a_out_last;
      tick();
      cyc++;
    end
    chk("dump_first_valid_cyc", 32'(first), 32'(exp_first));
    chk("dump_done_cyc", 32'(done_c), 32'(exp_done));
    chk("dump_beats_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    #1;
    chk("dump_idle_busy", 32'(a_busy), 32'd0);
    tick();
    chk("dump_still_idle", 32'(a_state), 32'(IDLE));
    chk("dump_done_count", 32'(a_done_cnt - c0), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] bw [3];
    bw[0] = 16'h1234; bw[1] = 16'h5678; bw[2] = 16'h9ABC;

    #12 rst = 1'b0;
    tick();
    #1;
    chk("rst_state", 32'(a_state), 32'(IDLE));
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_last", 32'(a_out_last), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_wr_en", 32'(a_wr_en), 32'd0);

    // Load AA..DD at full rate, then read back.
    load_a(32'hDDCC_BBAA, 16'h000F, 4);
    chk_reg_a(2'd0, 8'hAA);
    chk_reg_a(2'd1, 8'hBB);
    chk_reg_a(2'd2, 8'hCC);
    chk_reg_a(2'd3, 8'hDD);

    // Dump with ready high; start poked during DUMP and DONE.
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    dump_a(16'h0000, 0, 2, 6, 1'b1);

    // Dump with backpressure: ready 1,0,0,1,0,1,1.
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    dump_a(16'b0000_0000_0110_1001, 7, 2, 9, 1'b0);

    // Asynchronous reset mid-dump, after BB is presented.
    a_mode = MODE_DUMP; a_out_ready = 1'b1; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    #1;
    chk("rstmid_aa", 32'(a_out_data), 32'hAA);
    tick();
    #1;
    chk("rstmid_bb", 32'(a_out_data), 32'hBB);
    chk("rstmid_bb_valid", 32'(a_out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_valid", 32'(a_out_valid), 32'd0);
    chk("rstmid_busy", 32'(a_busy), 32'd0);
    chk("rstmid_state", 32'(a_state), 32'(IDLE));
    chk("rstmid_data", 32'(a_out_data), 32'd0);
    #1 rst = 1'b0;
    tick();
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    dump_a(16'h0000, 0, 2, 6, 1'b0);

    // Load with gaps: in_valid 1,0,1,1,0,1 carrying 11,22,33,44.
    load_a(32'h4433_2211, 16'b0000_0000_0010_1101, 6);
    chk_reg_a(2'd0, 8'h11);
    chk_reg_a(2'd1, 8'h22);
    chk_reg_a(2'd2, 8'h33);
    chk_reg_a(2'd3, 8'h44);

    // DUT B, LENGTH 3 / WIDTH 16: load then dump.
    b_mode = MODE_LOAD; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = bw[i];
      #1;
      chk("b_load_wr_addr", 32'(b_wr_addr), 32'(i));
      chk("b_load_wr_en", 32'(b_wr_en), 32'd1);
      tick();
    end
    b_in_valid = 1'b0;
    #1;
    chk("b_load_done", 32'(b_done), 32'd1);
    tick();
    b_rd_addr2 = 2'd2;
    #1;
    chk("b_reg2", 32'(b_rd_data2), 32'h9ABC);

    b_mode = MODE_DUMP; b_out_ready = 1'b1; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    #1;
    chk("b_dump_c1_valid", 32'(b_out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("b_dump_valid", 32'(b_out_valid), 32'd1);
      chk("b_dump_data", 32'(b_out_data), 32'(bw[i]));
      chk("b_dump_last", 32'(b_out_last), 32'(i == 2));
    end
    tick();
    #1;
    chk("b_dump_done", 32'(b_done), 32'd1);
    chk("b_dump_done_valid", 32'(b_out_valid), 32'd0);
    tick();
    #1;
    chk("b_dump_idle", 32'(b_busy), 32'd0);
    chk("b_done_count", 32'(b_done_cnt), 32'd2);
    chk("b_addr_range", 32'(b_bad_addr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_scan.md
# reg_scan

Sequential reader/loader for the CPU register file. On command it walks every register address in order. In dump mode it reads each register through a read port and streams the values out over a valid/ready handshake. In load mode it accepts a valid/ready input stream and writes each word into consecutive registers through the write port. It sits between the register file and the debug/test link, used for state snapshot and preload.

## Interface
- WIDTH, 8, register data width
- LENGTH, 4, number of registers; ADDR_WIDTH = $clog2(LENGTH)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  command strobe, sampled only in IDLE
- mode  in  1  sampled with start; 0 = dump, 1 = load
- busy  out  1  high in DUMP, LOAD, DONE
- done  out  1  one-cycle pulse in DONE
- rf_rd_addr  out  ADDR_WIDTH  register file read address
- rf_rd_data  in  WIDTH  combinational read data for rf_rd_addr
- rf_wr_addr  out  ADDR_WIDTH  register file write address
- rf_wr_data  out  WIDTH  register file write data
- rf_wr_en  out  1  register file write enable
- out_data  out  WIDTH  dump stream data, registered
- out_valid  out  1  dump stream valid, registered
- out_last  out  1  marks the beat from address LENGTH-1
- out_ready  in  1  dump stream ready
- in_data  in  WIDTH  load stream data
- in_valid  in  1  load stream valid
- in_ready  out  1  load stream ready; high only in LOAD

## Operation
- Reset values: state IDLE; idx 0; issued 0; out_data 0; out_valid 0; out_last 0. All other outputs decode to 0 from IDLE.
- State machine: IDLE -> DUMP or LOAD on start, selected by mode. DUMP/LOAD -> DONE on completion. DONE -> IDLE unconditionally.
- start is ignored outside IDLE. It is not queued.
- DUMP:
  - rf_rd_addr = idx.
  - The output register loads when !issued and (!out_valid or out_ready). The load sets out_data = rf_rd_data, out_valid = 1, and out_last = (idx == LENGTH-1).
  - On the same load, idx increments. On the load at idx == LENGTH-1, idx holds and issued is set.
  - If out_valid and out_ready and no new beat loads, out_valid clears.
  - Completion: handshake on a beat with out_last. On completion, out_valid and out_last clear.
  - idx must never wrap, including for non-power-of-2 LENGTH.
- LOAD:
  - in_ready = 1.
  - rf_wr_en = in_valid, rf_wr_addr = idx, rf_wr_data = in_data. These are combinational; the write lands at the next clk edge.
  - idx increments on each handshake.
  - Completion: the handshake at idx == LENGTH-1.
- DONE: done = 1, busy = 1. idx and issued clear.
- rf_wr_en is 0 in every state except LOAD. The rf_rd_addr value outside DUMP is don't-care; drive idx.
- Reset mid-operation: immediate return to reset values. A partially written register file is not restored. out_valid drops with no handshake.

## Timing
- start sampled at edge E0. E0+1 begins the DUMP/LOAD cycle with busy = 1.
- Dump:
  - The first out_valid is seen in the cycle after DUMP is entered: one cycle of read-to-output latency.
  - With out_ready held high, one beat per cycle.
  - LENGTH=4: beats in cycles 2..5 after the start edge, DONE in cycle 6, IDLE in cycle 7.
- Backpressure: out_data, out_valid and out_last hold stable while out_valid && !out_ready. No beat is dropped or duplicated.
- Load: one word per cycle at full rate. The DONE cycle follows the last handshake. The last write is visible in the register file in the DONE cycle.
- done pulses exactly once per command. busy is high from the cycle after start through DONE inclusive.

## Structure
- Package reg_scan_pkg holds:
  - state enum typedef {IDLE, DUMP, LOAD, DONE}
  - MODE_DUMP = 1'b0, MODE_LOAD = 1'b1
- No internal sub-module is needed. The output stage is a single registered beat.
- The bench instantiates reg_scan together with reg_file: rd_addr1/rd_data1 wired to rf_rd_*, write port wired to rf_wr_*, rd_addr2 left for checking.

## Test plan
- Load then dump, ready high:
  - rst, then load AA, BB, CC, DD -> registers 0..3 = AA, BB, CC, DD, and one done pulse.
  - Dump -> out_data AA, BB, CC, DD on four consecutive cycles, out_last on DD only, done one cycle later.
- Dump with backpressure: out_ready toggles 1,0,0,1,0,1,1 -> each of AA..DD is accepted exactly once, in order. out_data and out_valid are stable while stalled.
- Load with gaps: in_valid pattern 1,0,1,1,0,1 with words 11, 22, 33, 44 -> registers = 11, 22, 33, 44. rf_wr_en is asserted only on handshake cycles.
- start=1 pulsed during DUMP and during DONE -> ignored; exactly one done pulse and four beats.
- rst asserted asynchronously mid-dump after beat BB -> out_valid and busy drop immediately, without waiting for an edge. A new dump then restarts at address 0 and yields AA first.
- LENGTH=3, WIDTH=16: load 0x1234, 0x5678, 0x9ABC, then dump -> three beats, out_last on 0x9ABC, no access to address 3.
